// File: rtl/sagu_miss_replay.sv
// sagu_miss_replay
//   Store TLB-miss replay queue. Captures store micro-ops flagged with a TLB
//   miss by the store AGU into an in-order FIFO. It requests a page walk for
//   the oldest entry, then replays that entry back into the AGU mex_* inputs.
//   Walk faults go to retire instead of being replayed.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   except            pipeline flush (highest priority)
//   miss_*            miss capture from the AGU mOp stage
//   full, overflow    stall request / sticky overflow error
//   count             occupied entries
//   walk_*            page-walk request/response handshake
//   rpl_*             replay of the head entry into the AGU, rpl_gnt accepts
//   fault_*           one-cycle walk-fault report to retire
//
// FSM states
//   state    | meaning
//   S_IDLE   | decide next action for the head entry (or wait for one)
//   S_WREQ   | walk_req held for the head page until walk_ack
//   S_WWAIT  | walk in flight, waiting for walk_done
//   S_REPLAY | rpl_en held with head fields until rpl_gnt
module sagu_miss_replay #(
  parameter int DEPTH     = 4,
  parameter int OPW       = 8,
  parameter int REG_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   except,
  input  logic                   miss_en,
  input  logic [43:0]            miss_addr,
  input  logic [3:0]             miss_attr,
  input  logic [OPW-1:0]         miss_op,
  input  logic [REG_WIDTH-1:0]   miss_regno,
  input  logic [8:0]             miss_LSQ,
  input  logic [9:0]             miss_II,
  input  logic [5:0]             miss_WQ,
  input  logic                   miss_thread,
  input  logic                   miss_lsflag,
  output logic                   full,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] count,
  output logic                   walk_req,
  output logic [30:0]            walk_vpage,
  output logic                   walk_thread,
  output logic [3:0]             walk_attr,
  input  logic                   walk_ack,
  input  logic                   walk_done,
  input  logic                   walk_fault,
  output logic                   rpl_en,
  output logic [43:0]            rpl_addr,
  output logic [3:0]             rpl_attr,
  output logic [OPW-1:0]         rpl_op,
  output logic [REG_WIDTH-1:0]   rpl_regno,
  output logic [8:0]             rpl_LSQ,
  output logic [9:0]             rpl_II,
  output logic [5:0]             rpl_WQ,
  output logic                   rpl_thread,
  output logic                   rpl_lsflag,
  input  logic                   rpl_gnt,
  output logic                   fault_en,
  output logic [8:0]             fault_LSQ,
  output logic [9:0]             fault_II
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH - 1);

  typedef struct packed {
    logic [43:0]          addr;
    logic [3:0]           attr;
    logic [OPW-1:0]       op;
    logic [REG_WIDTH-1:0] regno;
    logic [8:0]           lsq;
    logic [9:0]           ii;
    logic [5:0]           wq;
    logic                 thread;
    logic                 lsflag;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_WREQ, S_WWAIT, S_REPLAY} state_t;

  state_t        state, state_nxt;
  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] head_ptr, tail_ptr;

  logic          lp_valid;
  logic          lp_thread;
  logic [30:0]   lp_vpage;
  logic          page_hit;

  logic          push, pop, fault_set, lp_load, lp_clear;

  assign head     = mem[head_ptr];
  assign page_hit = lp_valid && (head.thread == lp_thread) && (head.addr[43:13] == lp_vpage);
  assign push     = miss_en && !except && (count < DEPTH_C);
  assign full     = (count >= FULL_C);

  // next-state / control
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    fault_set = 1'b0;
    lp_load   = 1'b0;
    lp_clear  = 1'b0;
    if (except) begin
      state_nxt = S_IDLE;
      lp_clear  = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (count != '0) state_nxt = page_hit ? S_REPLAY : S_WREQ;
        end
        S_WREQ: begin
          if (walk_ack) state_nxt = S_WWAIT;
        end
        S_WWAIT: begin
          if (walk_done) begin
            if (walk_fault) begin
              pop       = 1'b1;
              fault_set = 1'b1;
              lp_clear  = 1'b1;
              state_nxt = S_IDLE;
            end else begin
              lp_load   = 1'b1;
              state_nxt = S_REPLAY;
            end
          end
        end
        S_REPLAY: begin
          if (rpl_gnt) begin
            pop       = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || except) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + PW'(1);
      if (pop)  head_ptr <= head_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // entry storage needs no reset; count qualifies every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail_ptr] <= '{addr: miss_addr, attr: miss_attr, op: miss_op,
                         regno: miss_regno, lsq: miss_LSQ, ii: miss_II,
                         wq: miss_WQ, thread: miss_thread, lsflag: miss_lsflag};
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      overflow <= 1'b0;
    else if (miss_en && !except && (count == DEPTH_C))
      overflow <= 1'b1;
  end

  // page of the last successful walk, used to skip re-walking the same page
  always_ff @(posedge clk) begin
    if (rst) begin
      lp_valid  <= 1'b0;
      lp_thread <= 1'b0;
      lp_vpage  <= '0;
    end else if (lp_clear) begin
      lp_valid  <= 1'b0;
    end else if (lp_load) begin
      lp_valid  <= 1'b1;
      lp_thread <= head.thread;
      lp_vpage  <= head.addr[43:13];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_en  <= 1'b0;
      fault_LSQ <= '0;
      fault_II  <= '0;
    end else begin
      fault_en <= fault_set;
      if (fault_set) begin
        fault_LSQ <= head.lsq;
        fault_II  <= head.ii;
      end
    end
  end

  // request outputs are zero unless their request is active, so nothing
  // from unwritten storage escapes after reset
  assign walk_req    = (state == S_WREQ);
  assign rpl_en      = (state == S_REPLAY);
  assign walk_vpage  = walk_req ? head.addr[43:13] : '0;
  assign walk_thread = walk_req ? head.thread      : 1'b0;
  assign walk_attr   = walk_req ? head.attr        : '0;

  assign rpl_addr    = rpl_en ? head.addr   : '0;
  assign rpl_attr    = rpl_en ? head.attr   : '0;
  assign rpl_op      = rpl_en ? head.op     : '0;
  assign rpl_regno   = rpl_en ? head.regno  : '0;
  assign rpl_LSQ     = rpl_en ? head.lsq    : '0;
  assign rpl_II      = rpl_en ? head.ii     : '0;
  assign rpl_WQ      = rpl_en ? head.wq     : '0;
  assign rpl_thread  = rpl_en ? head.thread : 1'b0;
  assign rpl_lsflag  = rpl_en ? head.lsflag : 1'b0;

endmodule

// File: tb/tb_sagu_miss_replay.sv
// Testbench for sagu_miss_replay: cycle tables for the single-miss and
// wrap sequences, hand-written sequences for shortcut, flush, fault and
// overflow behaviour.
module tb_sagu_miss_replay;

  localparam int DEPTH = 4;
  localparam int OPW = 8;
  localparam int REG_WIDTH = 6;

  logic clk, rst, except, miss_en;
  logic [43:0] miss_addr;
  logic [3:0] miss_attr;
  logic [OPW-1:0] miss_op;
  logic [REG_WIDTH-1:0] miss_regno;
  logic [8:0] miss_LSQ;
  logic [9:0] miss_II;
  logic [5:0] miss_WQ;
  logic miss_thread, miss_lsflag;
  logic full, overflow;
  logic [2:0] count;
  logic walk_req;
  logic [30:0] walk_vpage;
  logic walk_thread;
  logic [3:0] walk_attr;
  logic walk_ack, walk_done, walk_fault;
  logic rpl_en;
  logic [43:0] rpl_addr;
  logic [3:0] rpl_attr;
  logic [OPW-1:0] rpl_op;
  logic [REG_WIDTH-1:0] rpl_regno;
  logic [8:0] rpl_LSQ;
  logic [9:0] rpl_II;
  logic [5:0] rpl_WQ;
  logic rpl_thread, rpl_lsflag, rpl_gnt;
  logic fault_en;
  logic [8:0] fault_LSQ;
  logic [9:0] fault_II;

  sagu_miss_replay #(.DEPTH(DEPTH), .OPW(OPW), .REG_WIDTH(REG_WIDTH)) dut (
    .clk(clk), .rst(rst), .except(except), .miss_en(miss_en),
    .miss_addr(miss_addr), .miss_attr(miss_attr), .miss_op(miss_op),
    .miss_regno(miss_regno), .miss_LSQ(miss_LSQ), .miss_II(miss_II),
    .miss_WQ(miss_WQ), .miss_thread(miss_thread), .miss_lsflag(miss_lsflag),
    .full(full), .overflow(overflow), .count(count),
    .walk_req(walk_req), .walk_vpage(walk_vpage), .walk_thread(walk_thread),
    .walk_attr(walk_attr), .walk_ack(walk_ack), .walk_done(walk_done),
    .walk_fault(walk_fault), .rpl_en(rpl_en), .rpl_addr(rpl_addr),
    .rpl_attr(rpl_attr), .rpl_op(rpl_op), .rpl_regno(rpl_regno),
    .rpl_LSQ(rpl_LSQ), .rpl_II(rpl_II), .rpl_WQ(rpl_WQ),
    .rpl_thread(rpl_thread), .rpl_lsflag(rpl_lsflag), .rpl_gnt(rpl_gnt),
    .fault_en(fault_en), .fault_LSQ(fault_LSQ), .fault_II(fault_II)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  typedef struct {
    logic        rst, exc, men;
    logic [43:0] addr;
    logic [8:0]  lsq;
    logic        ack, done, flt, gnt;
    logic [2:0]  e_cnt;
    logic        e_full, e_wreq;
    logic [30:0] e_vpage;
    logic        e_rpl;
    logic [43:0] e_raddr;
    logic [8:0]  e_rlsq;
  } vec_t;

  vec_t vec[$];

  function automatic vec_t mk(logic r, logic x, logic m, logic [43:0] a, logic [8:0] l,
                              logic ak, logic dn, logic ft, logic g,
                              logic [2:0] ec, logic ef, logic ew, logic [30:0] ev,
                              logic er, logic [43:0] ea, logic [8:0] el);
    vec_t v;
    v.rst = r; v.exc = x; v.men = m; v.addr = a; v.lsq = l;
    v.ack = ak; v.done = dn; v.flt = ft; v.gnt = g;
    v.e_cnt = ec; v.e_full = ef; v.e_wreq = ew; v.e_vpage = ev;
    v.e_rpl = er; v.e_raddr = ea; v.e_rlsq = el;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_miss(logic en, logic [43:0] a, logic [8:0] l, logic [9:0] ii);
    miss_en = en; miss_addr = a; miss_LSQ = l; miss_II = ii;
  endtask

  localparam logic [43:0] A  = 44'h0_1234_5678;
  localparam logic [30:0] VA = 31'h91A2;
  localparam logic [43:0] W  = 44'h5_5555_4000;
  localparam logic [30:0] VW = 31'h2A_AAAA;

  int nreq, nrpl;
  int got[$];

  initial begin
    rst = 1'b0; except = 1'b0; miss_en = 1'b0; miss_addr = '0; miss_attr = '0;
    miss_op = '0; miss_regno = '0; miss_LSQ = '0; miss_II = '0; miss_WQ = '0;
    miss_thread = 1'b0; miss_lsflag = 1'b0;
    walk_ack = 1'b0; walk_done = 1'b0; walk_fault = 1'b0; rpl_gnt = 1'b0;

    // single miss: walk_ack next cycle, walk_done three cycles later
    vec.push_back(mk(1,0,0,0,0, 0,0,0,0, 0,0,0,0,  0,0,0));
    vec.push_back(mk(0,0,1,A,5, 0,0,0,0, 1,0,0,0,  0,0,0));
    vec.push_back(mk(0,0,0,0,0, 0,0,0,0, 1,0,1,VA, 0,0,0));
    vec.push_back(mk(0,0,0,0,0, 1,0,0,0, 1,0,0,0,  0,0,0));
    vec.push_back(mk(0,0,0,0,0, 0,0,0,0, 1,0,0,0,  0,0,0));
    vec.push_back(mk(0,0,0,0,0, 0,0,0,0, 1,0,0,0,  0,0,0));
    vec.push_back(mk(0,0,0,0,0, 0,1,0,0, 1,0,0,0,  1,A,5));
    vec.push_back(mk(0,0,0,0,0, 0,0,0,1, 0,0,0,0,  0,0,0));
    vec.push_back(mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0,  0,0,0));
    // wrap: six entries through four slots, walker/AGU always ready
    vec.push_back(mk(1,0,0,0,0,    0,0,0,0, 0,0,0,0,  0,0,0));
    vec.push_back(mk(0,0,1,W+8,1,  1,1,0,1, 1,0,0,0,  0,0,0));
    vec.push_back(mk(0,0,1,W+16,2, 1,1,0,1, 2,0,1,VW, 0,0,0));
    vec.push_back(mk(0,0,1,W+24,3, 1,1,0,1, 3,1,0,0,  0,0,0));
    vec.push_back(mk(0,0,0,0,0,    1,1,0,1, 3,1,0,0,  1,W+8,1));
    vec.push_back(mk(0,0,1,W+32,4, 1,1,0,1, 3,1,0,0,  0,0,0));
    vec.push_back(mk(0,0,0,0,0,    1,1,0,1, 3,1,0,0,  1,W+16,2));
    vec.push_back(mk(0,0,1,W+40,5, 1,1,0,1, 3,1,0,0,  0,0,0));
    vec.push_back(mk(0,0,1,W+48,6, 1,1,0,1, 4,1,0,0,  1,W+24,3));
    vec.push_back(mk(0,0,0,0,0,    1,1,0,1, 3,1,0,0,  0,0,0));
    vec.push_back(mk(0,0,0,0,0,    1,1,0,1, 3,1,0,0,  1,W+32,4));
    vec.push_back(mk(0,0,0,0,0,    1,1,0,1, 2,0,0,0,  0,0,0));
    vec.push_back(mk(0,0,0,0,0,    1,1,0,1, 2,0,0,0,  1,W+40,5));
    vec.push_back(mk(0,0,0,0,0,    1,1,0,1, 1,0,0,0,  0,0,0));
    vec.push_back(mk(0,0,0,0,0,    1,1,0,1, 1,0,0,0,  1,W+48,6));
    vec.push_back(mk(0,0,0,0,0,    1,1,0,1, 0,0,0,0,  0,0,0));
    vec.push_back(mk(0,0,0,0,0,    1,1,0,1, 0,0,0,0,  0,0,0));

    foreach (vec[i]) begin
      rst = vec[i].rst; except = vec[i].exc;
      set_miss(vec[i].men, vec[i].addr, vec[i].lsq, '0);
      walk_ack = vec[i].ack; walk_done = vec[i].done;
      walk_fault = vec[i].flt; rpl_gnt = vec[i].gnt;
      tick();
      chk($sformatf("row%0d count", i), 64'(count), 64'(vec[i].e_cnt));
      chk($sformatf("row%0d full", i), 64'(full), 64'(vec[i].e_full));
      chk($sformatf("row%0d walk_req", i), 64'(walk_req), 64'(vec[i].e_wreq));
      chk($sformatf("row%0d walk_vpage", i), 64'(walk_vpage), 64'(vec[i].e_vpage));
      chk($sformatf("row%0d rpl_en", i), 64'(rpl_en), 64'(vec[i].e_rpl));
      chk($sformatf("row%0d rpl_addr", i), 64'(rpl_addr), 64'(vec[i].e_raddr));
      chk($sformatf("row%0d rpl_LSQ", i), 64'(rpl_LSQ), 64'(vec[i].e_rlsq));
      chk($sformatf("row%0d fault_en", i), 64'(fault_en), 64'(0));
      chk($sformatf("row%0d overflow", i), 64'(overflow), 64'(0));
    end
    rst = 1'b0;

    // same-page shortcut: two misses in page 0x91A2, one walk, in-order replay
    walk_ack = 1'b1; walk_done = 1'b1; rpl_gnt = 1'b1;
    nreq = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 0)      set_miss(1'b1, 44'h0_1234_5000, 9'd1, '0);
      else if (c == 1) set_miss(1'b1, 44'h0_1234_5100, 9'd2, '0);
      else             set_miss(1'b0, '0, '0, '0);
      tick();
      if (walk_req) nreq++;
      if (rpl_en) got.push_back(int'(rpl_LSQ));
    end
    chk("shortcut walk_req count", 64'(nreq), 64'(1));
    chk("shortcut grant count", 64'(got.size()), 64'(2));
    if (got.size() == 2) begin
      chk("shortcut first LSQ", 64'(got[0]), 64'(1));
      chk("shortcut second LSQ", 64'(got[1]), 64'(2));
    end
    chk("shortcut final count", 64'(count), 64'(0));

    // flush mid-walk (with a same-cycle miss), then a late walk_done
    walk_done = 1'b0; rpl_gnt = 1'b0; walk_ack = 1'b1;
    set_miss(1'b1, 44'h0_3000_0000, 9'd20, '0); tick();
    set_miss(1'b0, '0, '0, '0); tick();
    chk("flush walk_req before", 64'(walk_req), 64'(1));
    tick(); tick();
    except = 1'b1; set_miss(1'b1, 44'h0_3000_0008, 9'd21, '0); tick();
    except = 1'b0; set_miss(1'b0, '0, '0, '0);
    chk("flush count", 64'(count), 64'(0));
    chk("flush walk_req", 64'(walk_req), 64'(0));
    walk_done = 1'b1; tick(); walk_done = 1'b0;
    nrpl = 0;
    for (int c = 0; c < 4; c++) begin
      if (rpl_en || walk_req || count != 0) nrpl++;
      tick();
    end
    chk("flush quiet after late done", 64'(nrpl), 64'(0));
    // page 0x91A2 was walked before the flush; it must be walked again
    set_miss(1'b1, 44'h0_1234_5000, 9'd22, '0); tick();
    set_miss(1'b0, '0, '0, '0); tick();
    chk("flush last_page invalid walk_req", 64'(walk_req), 64'(1));
    chk("flush last_page invalid rpl_en", 64'(rpl_en), 64'(0));
    except = 1'b1; tick(); except = 1'b0;

    // walk fault: report to retire, no replay, entry popped
    walk_ack = 1'b1;
    set_miss(1'b1, 44'h0_ABCD_E000, 9'd7, 10'h55); tick();
    set_miss(1'b0, '0, '0, '0); tick();
    chk("fault walk_req", 64'(walk_req), 64'(1));
    tick();
    walk_done = 1'b1; walk_fault = 1'b1; tick();
    walk_done = 1'b0; walk_fault = 1'b0;
    chk("fault fault_en", 64'(fault_en), 64'(1));
    chk("fault fault_LSQ", 64'(fault_LSQ), 64'(7));
    chk("fault fault_II", 64'(fault_II), 64'(10'h55));
    chk("fault count", 64'(count), 64'(0));
    chk("fault rpl_en", 64'(rpl_en), 64'(0));
    tick();
    chk("fault fault_en pulse", 64'(fault_en), 64'(0));
    chk("fault no replay", 64'(rpl_en), 64'(0));

    // full/overflow with the walker stalled
    walk_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_miss(1'b1, 44'h0_2000_0000 + 44'(k), 9'(10 + k), '0);
      tick();
      chk($sformatf("fill%0d count", k), 64'(count), 64'((k < 4) ? k + 1 : 4));
      chk($sformatf("fill%0d full", k), 64'(full), 64'((k >= 2) ? 1 : 0));
      chk($sformatf("fill%0d overflow", k), 64'(overflow), 64'((k == 4) ? 1 : 0));
    end
    set_miss(1'b0, '0, '0, '0);
    chk("fill walk_vpage held", 64'(walk_vpage), 64'(31'h1_0000));
    chk("fill rpl_en", 64'(rpl_en), 64'(0));
    except = 1'b1; tick(); except = 1'b0;
    chk("overflow sticky", 64'(overflow), 64'(1));
    chk("flush clears count", 64'(count), 64'(0));
    chk("flush clears full", 64'(full), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
